// File: rtl/mul_div_unit.sv
// Purpose : multi-cycle signed WIDTHxWIDTH multiply (radix-2 Booth) / divide (restoring) into {HI,LO}.
// Latency : start accepted at edge t0 -> done high after edge t0+WIDTH+1, for every operation.
// Backpr. : none; start is ignored while busy, and done is a one-cycle pulse with no stall.
module mul_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic                 clock,
   input  logic                 clear,
   input  logic                 start,
   input  logic                 op,
   input  logic [WIDTH-1:0]     A,
   input  logic [WIDTH-1:0]     B,
   output logic                 busy,
   output logic                 done,
   output logic                 div_by_zero,
   output logic [2*WIDTH-1:0]   Z
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t state, state_nxt;

   logic          accept;
   logic          last_iter;
   logic [CW-1:0] cnt;

   // latched operation context
   logic             op_r;
   logic [WIDTH-1:0] a_r;
   logic             a_neg;
   logic             q_neg;
   logic             b_zero;
   logic             dbz_r;

   // multiply datapath: Booth accumulator {upper, multiplier, q-1}
   logic [2*WIDTH:0] acc;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH:0]   upper_ext;
   logic [WIDTH:0]   mcand_ext;
   logic [WIDTH:0]   booth_sum;

   // divide datapath: partial remainder and dividend/quotient shift register
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] bmag;
   logic [WIDTH:0]   shifted;
   logic [WIDTH-1:0] trial;
   logic             fits;

   logic [WIDTH-1:0] a_mag_in;
   logic [WIDTH-1:0] b_mag_in;
   logic [WIDTH-1:0] q_fix;
   logic [WIDTH-1:0] r_fix;

   // state register; clear wins over everything, including a same-edge start
   always_ff @(posedge clock) begin
      if (clear) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_CALC;
         S_CALC:  if (last_iter) state_nxt = S_FIX;
         S_FIX:   state_nxt = S_DONE;
         S_DONE:  state_nxt = start ? S_CALC : S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // FSM outputs; DONE is not busy so a new request can be issued during the done pulse
   always_comb begin
      busy        = (state == S_CALC) || (state == S_FIX);
      done        = (state == S_DONE);
      div_by_zero = (state == S_DONE) && dbz_r;
      accept      = start && ((state == S_IDLE) || (state == S_DONE));
   end

   // per-iteration arithmetic for both engines
   always_comb begin
      last_iter = (cnt == CW'(WIDTH - 1));
      a_mag_in  = A[WIDTH-1] ? (~A + 1'b1) : A;
      b_mag_in  = B[WIDTH-1] ? (~B + 1'b1) : B;

      // Booth step: the add is one bit wider than the upper half so that
      // subtracting the most negative multiplicand cannot overflow
      upper_ext = {acc[2*WIDTH], acc[2*WIDTH:WIDTH+1]};
      mcand_ext = {mcand[WIDTH-1], mcand};
      case (acc[1:0])
         2'b01:   booth_sum = upper_ext + mcand_ext;
         2'b10:   booth_sum = upper_ext - mcand_ext;
         default: booth_sum = upper_ext;
      endcase

      // restoring step: the remainder stays below |B| <= 2^(WIDTH-1), so the
      // difference always fits WIDTH bits whenever the trial subtraction succeeds
      shifted = {rem, quo[WIDTH-1]};
      fits    = (shifted >= {1'b0, bmag});
      trial   = shifted[WIDTH-1:0] - bmag;

      q_fix = q_neg ? (~quo + 1'b1) : quo;
      r_fix = a_neg ? (~rem + 1'b1) : rem;
   end

   // datapath registers: operand capture, iteration, and sign fix-up into Z
   always_ff @(posedge clock) begin
      if (clear) begin
         cnt    <= '0;
         op_r   <= 1'b0;
         a_r    <= '0;
         a_neg  <= 1'b0;
         q_neg  <= 1'b0;
         b_zero <= 1'b0;
         dbz_r  <= 1'b0;
         acc    <= '0;
         mcand  <= '0;
         rem    <= '0;
         quo    <= '0;
         bmag   <= '0;
         Z      <= '0;
      end else begin
         if (accept) begin
            cnt    <= '0;
            op_r   <= op;
            a_r    <= A;
            a_neg  <= A[WIDTH-1];
            q_neg  <= A[WIDTH-1] ^ B[WIDTH-1];
            b_zero <= (B == '0);
            dbz_r  <= 1'b0;
            acc    <= {{WIDTH{1'b0}}, B, 1'b0};
            mcand  <= A;
            rem    <= '0;
            quo    <= a_mag_in;
            bmag   <= b_mag_in;
         end else if (state == S_CALC) begin
            cnt <= cnt + 1'b1;
            if (!op_r) begin
               acc <= {booth_sum, acc[WIDTH:1]};
            end else begin
               rem <= fits ? trial : shifted[WIDTH-1:0];
               quo <= {quo[WIDTH-2:0], fits};
            end
         end else if (state == S_FIX) begin
            if (!op_r)       Z <= acc[2*WIDTH:1];
            else if (b_zero) Z <= {a_r, {WIDTH{1'b1}}};
            else             Z <= {r_fix, q_fix};
            dbz_r <= op_r && b_zero;
         end
      end
   end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed-vector bench: stimulus pushes expected {Z, div_by_zero, done cycle}
// into queues; a negedge monitor pops and compares on every done pulse.
module tb_mul_div_unit;

   localparam int W   = 32;
   localparam int LAT = W + 1;

   logic            clock = 1'b0;
   logic            clear;
   logic            start;
   logic            op;
   logic [W-1:0]    A;
   logic [W-1:0]    B;
   logic            busy;
   logic            done;
   logic            div_by_zero;
   logic [2*W-1:0]  Z;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   int busy_run = 0;

   logic [2*W-1:0] exp_z   [$];
   logic           exp_dbz [$];
   int             exp_cyc [$];

   mul_div_unit #(.WIDTH(W)) dut (
      .clock       (clock),
      .clear       (clear),
      .start       (start),
      .op          (op),
      .A           (A),
      .B           (B),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero),
      .Z           (Z)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got 0x%h, expected 0x%h", name, act, req);
      end
   endtask

   // monitor: every done pulse must match the oldest outstanding request
   always @(negedge clock) begin
      if (clear) begin
         busy_run = 0;
      end else if (done) begin
         if (exp_z.size() == 0) begin
            check("unexpected_done", 64'd1, 64'd0);
         end else begin
            check("Z", Z, exp_z.pop_front());
            check("div_by_zero", {63'd0, div_by_zero}, {63'd0, exp_dbz.pop_front()});
            check("latency", 64'(cyc), 64'(exp_cyc.pop_front()));
            // busy covers WIDTH CALC cycles plus the FIX cycle, and drops for DONE
            check("busy_run", 64'(busy_run), 64'(LAT));
            check("busy_in_done", {63'd0, busy}, 64'd0);
         end
         busy_run = 0;
      end else if (busy) begin
         busy_run++;
      end else begin
         busy_run = 0;
      end
   end

   // drive a request at the current negedge; the next rising edge accepts it
   task automatic drive(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] ez, input logic ed);
      start = 1'b1; op = o; A = a; B = b;
      exp_z.push_back(ez);
      exp_dbz.push_back(ed);
      exp_cyc.push_back(cyc + 1 + LAT);
      @(negedge clock);
      start = 1'b0;
      A = $urandom;
      B = $urandom;
   endtask

   task automatic issue(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] ez, input logic ed);
      @(negedge clock);
      drive(o, a, b, ez, ed);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (n < 200 && !(exp_z.size() == 0 && !busy && !done)) begin
         @(negedge clock);
         n++;
      end
      if (n >= 200) check("wait_idle_timeout", 64'd1, 64'd0);
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      @(negedge clock);
      while (n < 200 && !done) begin
         @(negedge clock);
         n++;
      end
      if (n >= 200) check("wait_done_timeout", 64'd1, 64'd0);
   endtask

   initial begin
      clear = 1'b1; start = 1'b0; op = 1'b0; A = '0; B = '0;
      repeat (2) @(negedge clock);
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_done", {63'd0, done}, 64'd0);
      check("rst_dbz",  {63'd0, div_by_zero}, 64'd0);
      check("rst_Z", Z, 64'd0);
      clear = 1'b0;

      // multiplies
      issue(1'b0, 32'd7,        32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0);
      wait_idle();
      issue(1'b0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0);
      wait_idle();
      issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0);
      wait_idle();
      issue(1'b0, 32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000, 1'b0);
      wait_idle();

      // divides
      issue(1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0);
      wait_idle();
      issue(1'b1, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0);
      wait_idle();
      repeat (3) @(negedge clock);
      check("Z_hold_idle", Z, {32'd2, 32'd14});
      issue(1'b1, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, 1'b0);
      wait_idle();
      issue(1'b1, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF}, 1'b1);
      wait_idle();
      issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 1'b0);
      wait_idle();

      // abort with clear on the 10th CALC edge: no done, outputs cleared
      @(negedge clock);
      start = 1'b1; op = 1'b0; A = 32'd11; B = 32'd13;
      @(negedge clock);
      start = 1'b0;
      repeat (9) @(negedge clock);
      clear = 1'b1;
      @(negedge clock);
      check("abort_busy", {63'd0, busy}, 64'd0);
      check("abort_done", {63'd0, done}, 64'd0);
      check("abort_Z", Z, 64'd0);
      clear = 1'b0;

      // start pulsed mid-CALC must be ignored
      issue(1'b0, 32'd3, 32'd4, 64'd12, 1'b0);
      repeat (5) @(negedge clock);
      start = 1'b1; op = 1'b1; A = 32'd100; B = 32'd7;
      @(negedge clock);
      start = 1'b0;
      wait_idle();
      repeat (40) @(negedge clock);
      check("ignored_start_Z", Z, 64'd12);

      // back-to-back: second request issued during the first done cycle
      issue(1'b0, 32'd6, 32'd7, 64'd42, 1'b0);
      wait_done();
      drive(1'b1, 32'd9, 32'd4, {32'd1, 32'd2}, 1'b0);
      wait_idle();
      repeat (5) @(negedge clock);

      if (exp_z.size() != 0) check("missing_done", 64'(exp_z.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
